// File: rtl/openeth_mem_arb_pkg.sv
// Shared definitions for the two-requester Avalon-MM memory arbiter.
// The state encodings are kept as plain localparams so older code that
// compares against the raw two-bit values keeps working.

package openeth_mem_arb_pkg;

    // Arbiter states: nobody owns the port, or requester 0 / 1 owns it.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OWN0 = 2'b01;
    localparam logic [1:0] ST_OWN1 = 2'b10;

    // Width of the per-grant completion counter, which must reach hold_max.
    function automatic int hold_cnt_width(input int hold_max);
        return (hold_max < 1) ? 1 : $clog2(hold_max + 1);
    endfunction

    // One-hot grant vector for a state; the owned states already are one-hot.
    function automatic logic [1:0] grant_of(input logic [1:0] st);
        logic [1:0] g;
        case (st)
            ST_OWN0: g = 2'b01;
            ST_OWN1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // The owned state belonging to the requester that is not the owner of st.
    function automatic logic [1:0] other_owner(input logic [1:0] st);
        return (st == ST_OWN0) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/openeth_mem_arb.sv
// Two-requester Avalon-MM arbiter in front of one word-addressed memory port.
// Requester 0 is the MAC DMA master, requester 1 the descriptor/CPU bridge.
// Ownership alternates round-robin; an owner may keep the port for at most
// HOLD_MAX completed transfers while the other side waits, and a stalled
// transfer is never interrupted. All slave-side outputs are a combinational
// mux of the registered owner, so a reset drops s_read/s_write immediately.

module openeth_mem_arb
    import openeth_mem_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int DW       = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [29:0]         m0_address,
    input  logic [DW/8-1:0]     m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DW-1:0]       m0_writedata,
    output logic [DW-1:0]       m0_readdata,
    output logic                m0_waitrequest,

    input  logic [29:0]         m1_address,
    input  logic [DW/8-1:0]     m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DW-1:0]       m1_writedata,
    output logic [DW-1:0]       m1_readdata,
    output logic                m1_waitrequest,

    output logic [29:0]         s_address,
    output logic [DW/8-1:0]     s_byteenable,
    output logic                s_read,
    output logic                s_write,
    output logic [DW-1:0]       s_writedata,
    input  logic [DW-1:0]       s_readdata,
    input  logic                s_waitrequest,

    output logic [1:0]          grant
);

    localparam int CW = hold_cnt_width(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW:0]   HOLD_CMP = (CW + 1)'(HOLD_MAX);

    // A hold of zero would let an owner be pre-empted before it finishes
    // anything, which the round-robin below cannot express.
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("openeth_mem_arb: HOLD_MAX must be at least 1");
    end

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          last;
    logic          last_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic          req0;
    logic          req1;
    logic          own0;
    logic          own1;
    logic          owner_req;
    logic          other_req;
    logic          owner_idx;
    logic [CW:0]   cnt_inc;
    logic          hold_reached;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);

    // Request lines seen from the owner's point of view.
    assign owner_req = (own0 & req0) | (own1 & req1);
    assign other_req = (own0 & req1) | (own1 & req0);
    assign owner_idx = own1;

    // cnt_inc is one bit wider so the comparison cannot wrap at saturation.
    assign cnt_inc      = {1'b0, cnt} + (CW + 1)'(1);
    assign hold_reached = (cnt_inc >= HOLD_CMP);

    // Next owner, last-owner and completion count from the current request picture.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_nxt = ST_OWN0;
                end else if (req1) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!owner_req) begin
                    last_nxt  = owner_idx;
                    cnt_nxt   = '0;
                    state_nxt = other_req ? other_owner(state) : ST_IDLE;
                end else if (!s_waitrequest) begin
                    if (hold_reached && other_req) begin
                        last_nxt  = owner_idx;
                        cnt_nxt   = '0;
                        state_nxt = other_owner(state);
                    end else begin
                        cnt_nxt = hold_reached ? HOLD_LIM : cnt_inc[CW-1:0];
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Arbiter registers; last starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Slave-side mux and per-requester waitrequest driven from the registered owner.
    always_comb begin
        s_address      = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            ST_OWN0: begin
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest;
            end
            ST_OWN1: begin
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
                s_read = 1'b0;
            end
        endcase
    end

    assign grant       = grant_of(state);
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // The grant can never name both requesters at once.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));

    // The completion counter never runs past the hold limit.
    a_cnt_bounded: assert property (@(posedge clk) disable iff (!reset_n) cnt <= HOLD_LIM);

endmodule

// File: tb/tb_openeth_mem_arb.sv
// Self-checking bench for openeth_mem_arb: directed scenarios with literal
// expectations, then randomized Avalon traffic compared every cycle against
// an ownership model kept in terms of "who owns the port, who went last and
// how many transfers the owner has finished".

module tb_openeth_mem_arb;

    localparam int HOLD_MAX = 4;
    localparam int DW       = 32;
    localparam int BW       = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;

    logic [29:0]   m0_address,  m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [29:0]   s_address;
    logic [BW-1:0] s_byteenable;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [DW-1:0] s_readdata;
    logic          s_waitrequest;
    logic [1:0]    grant;

    int n_cmp = 0;
    int n_bad = 0;

    openeth_mem_arb #(.HOLD_MAX(HOLD_MAX), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural ownership model ----------------
    int mdl_owner = -1;
    int mdl_last  = 1;
    int mdl_run   = 0;

    // Who owns the port next, from the arbitration rules.
    always @(posedge clk or negedge reset_n) begin : model_step
        int o, l, r;
        bit [1:0] q;
        if (!reset_n) begin
            mdl_owner <= -1;
            mdl_last  <= 1;
            mdl_run   <= 0;
        end else begin
            q = {m1_read | m1_write, m0_read | m0_write};
            o = mdl_owner;
            l = mdl_last;
            r = mdl_run;
            if (o < 0) begin
                if (q == 2'b11) o = 1 - l;
                else if (q[0]) o = 0;
                else if (q[1]) o = 1;
            end else if (!q[o]) begin
                l = o;
                r = 0;
                o = q[1-o] ? 1 - o : -1;
            end else if (!s_waitrequest) begin
                r = r + 1;
                if (r >= HOLD_MAX && q[1-o]) begin
                    l = o;
                    o = 1 - o;
                    r = 0;
                end else if (r > HOLD_MAX) begin
                    r = HOLD_MAX;
                end
            end
            mdl_owner <= o;
            mdl_last  <= l;
            mdl_run   <= r;
        end
    end

    // Every cycle, the outputs the current owner implies.
    always @(negedge clk) begin : compare
        logic [1:0]    eg;
        logic          erd, ewr, ew0, ew1;
        logic [29:0]   ea;
        logic [BW-1:0] ebe;
        logic [DW-1:0] ewd;
        eg = 2'b00; erd = 1'b0; ewr = 1'b0; ea = '0; ebe = '0; ewd = '0;
        ew0 = 1'b1; ew1 = 1'b1;
        if (mdl_owner == 0) begin
            eg = 2'b01; erd = m0_read; ewr = m0_write; ea = m0_address;
            ebe = m0_byteenable; ewd = m0_writedata; ew0 = s_waitrequest;
        end else if (mdl_owner == 1) begin
            eg = 2'b10; erd = m1_read; ewr = m1_write; ea = m1_address;
            ebe = m1_byteenable; ewd = m1_writedata; ew1 = s_waitrequest;
        end
        checkOutput("grant",        64'(grant),          64'(eg));
        checkOutput("s_read",       64'(s_read),         64'(erd));
        checkOutput("s_write",      64'(s_write),        64'(ewr));
        checkOutput("s_address",    64'(s_address),      64'(ea));
        checkOutput("s_byteenable", 64'(s_byteenable),   64'(ebe));
        checkOutput("s_writedata",  64'(s_writedata),    64'(ewd));
        checkOutput("m0_wait",      64'(m0_waitrequest), 64'(ew0));
        checkOutput("m1_wait",      64'(m1_waitrequest), 64'(ew1));
        checkOutput("m0_readdata",  64'(m0_readdata),    64'(s_readdata));
        checkOutput("m1_readdata",  64'(m1_readdata),    64'(s_readdata));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle();
        m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
        s_readdata = '0; s_waitrequest = 0;
    endtask

    // Pulse reset; returns just after the releasing clock edge.
    task automatic doReset();
        step();
        reset_n = 0;
        driveIdle();
        step();
        step();
        reset_n = 1;
    endtask

    task automatic genTxn(output logic rd, output logic wr, output logic [29:0] a,
                          output logic [BW-1:0] be, output logic [DW-1:0] wd);
        int p;
        p  = $urandom_range(0, 99);
        rd = (p < 30);
        wr = (p >= 30 && p < 60);
        a  = 30'($urandom);
        be = BW'($urandom);
        wd = DW'($urandom);
    endtask

    // Random Avalon masters that hold a request until it completes.
    task automatic applyStimulus(input int cycles);
        logic d0, d1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            d0 = (m0_read | m0_write) & ~m0_waitrequest;
            d1 = (m1_read | m1_write) & ~m1_waitrequest;
            step();
            if (i == cycles / 2) reset_n = 1'b1;
            if (!(m0_read | m0_write) || d0)
                genTxn(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
            if (!(m1_read | m1_write) || d1)
                genTxn(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
            s_waitrequest = ($urandom_range(0, 99) < 35);
            s_readdata    = DW'($urandom);
            if (i == cycles / 2 - 2) begin
                #2;
                reset_n = 1'b0;
            end
        end
    endtask

    // ---------------- directed scenarios + random run ----------------
    int order[$];
    int exp_order[7] = '{0, 0, 0, 0, 1, 0, 0};
    int left;
    logic c0, c1;

    initial begin
        reset_n = 0;
        driveIdle();
        @(negedge clk);
        checkOutput("rst_grant", 64'(grant),          64'(0));
        checkOutput("rst_sread", 64'(s_read),         64'(0));
        checkOutput("rst_wait0", 64'(m0_waitrequest), 64'(1));
        checkOutput("rst_wait1", 64'(m1_waitrequest), 64'(1));

        // m0 read alone with a two-cycle memory stall.
        doReset();
        m0_read = 1; m0_address = 30'h123; s_waitrequest = 1; s_readdata = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("t1_idle_sread", 64'(s_read), 64'(0));
        step();
        @(negedge clk);
        checkOutput("t1_sread",  64'(s_read),         64'(1));
        checkOutput("t1_grant",  64'(grant),          64'(2'b01));
        checkOutput("t1_saddr",  64'(s_address),      64'(30'h123));
        checkOutput("t1_wait_a", 64'(m0_waitrequest), 64'(1));
        step();
        @(negedge clk);
        checkOutput("t1_wait_b", 64'(m0_waitrequest), 64'(1));
        step();
        s_waitrequest = 0;
        @(negedge clk);
        checkOutput("t1_wait_c", 64'(m0_waitrequest), 64'(0));
        checkOutput("t1_rdata",  64'(m0_readdata),    64'(32'hDEADBEEF));
        step();
        m0_read = 0;
        @(negedge clk);
        checkOutput("t1_drop_grant", 64'(grant),  64'(2'b01));
        checkOutput("t1_drop_sread", 64'(s_read), 64'(0));
        step();
        @(negedge clk);
        checkOutput("t1_idle_grant", 64'(grant),          64'(0));
        checkOutput("t1_idle_swr",   64'(s_write),        64'(0));
        checkOutput("t1_idle_w0",    64'(m0_waitrequest), 64'(1));
        checkOutput("t1_idle_w1",    64'(m1_waitrequest), 64'(1));

        // Simultaneous m0 read and m1 write right after reset.
        doReset();
        m0_read = 1; m1_write = 1; m1_writedata = 32'h0BADF00D;
        @(negedge clk);
        checkOutput("t2_idle", 64'(grant), 64'(0));
        step();
        @(negedge clk);
        checkOutput("t2_first", 64'(grant), 64'(2'b01));
        step();
        m0_read = 0;
        @(negedge clk);
        checkOutput("t2_hold", 64'(grant), 64'(2'b01));
        step();
        @(negedge clk);
        checkOutput("t2_second", 64'(grant),       64'(2'b10));
        checkOutput("t2_swrite", 64'(s_write),     64'(1));
        checkOutput("t2_wdata",  64'(s_writedata), 64'(32'h0BADF00D));
        step();
        m1_write = 0;

        // Bounded hold: six m0 writes against a waiting m1 read.
        doReset();
        m0_write = 1; m1_read = 1; left = 6;
        order.delete();
        for (int i = 0; i < 40 && (left > 0 || m1_read); i++) begin
            @(negedge clk);
            c0 = (grant == 2'b01) && !m0_waitrequest && m0_write;
            c1 = (grant == 2'b10) && !m1_waitrequest && m1_read;
            if (c0) order.push_back(0);
            if (c1) order.push_back(1);
            step();
            if (c0) begin
                left--;
                if (left == 0) m0_write = 0;
                else m0_address = m0_address + 30'd1;
            end
            if (c1) m1_read = 0;
        end
        checkOutput("t3_timeout", 64'(left), 64'(0));
        checkOutput("t3_count",   64'(order.size()), 64'(7));
        for (int i = 0; i < 7; i++)
            checkOutput("t3_order", 64'(i < order.size() ? order[i] : -1), 64'(exp_order[i]));
        driveIdle();

        // Long stall on m0 while m1 waits.
        doReset();
        m0_read = 1; s_waitrequest = 1;
        step();
        m1_read = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t4_grant", 64'(grant),          64'(2'b01));
            checkOutput("t4_wait1", 64'(m1_waitrequest), 64'(1));
            step();
        end
        s_waitrequest = 0;
        step();
        m0_read = 0;
        step();
        @(negedge clk);
        checkOutput("t4_after", 64'(grant), 64'(2'b10));
        step();
        driveIdle();

        // Reset while m1 has a write stalled at the memory.
        doReset();
        m1_write = 1; m1_writedata = 32'h12345678; s_waitrequest = 1;
        step();
        @(negedge clk);
        checkOutput("t5_swrite", 64'(s_write), 64'(1));
        step();
        #2;
        reset_n = 0;
        #1;
        checkOutput("t5_abort_swrite", 64'(s_write), 64'(0));
        checkOutput("t5_abort_grant",  64'(grant),   64'(0));
        m1_write = 0;
        step();
        step();
        reset_n = 1;
        m0_read = 1;
        @(negedge clk);
        checkOutput("t5_lat0", 64'(s_read), 64'(0));
        step();
        @(negedge clk);
        checkOutput("t5_lat1",   64'(s_read), 64'(1));
        checkOutput("t5_grant0", 64'(grant),  64'(2'b01));
        s_waitrequest = 0;
        step();
        driveIdle();
        step();

        // Randomized traffic with one asynchronous reset in the middle.
        applyStimulus(1600);
        driveIdle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
